// File: rtl/reg_file_cfg_pkg.sv
// Shared constants for the reg_file_cfg configuration register file:
// default geometry and the non-zero reset values of entries 2 and 3.
package reg_file_cfg_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;

  // Reset values are defined at 8 bits and resized to WIDTH at the use site.
  localparam logic [7:0] RST_VAL2 = 8'b1000_0001;
  localparam logic [7:0] RST_VAL3 = 8'd32;

  // Reset value of entry idx (8-bit form).
  function automatic logic [7:0] rst_val(input int idx);
    case (idx)
      2:       return RST_VAL2;
      3:       return RST_VAL3;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/reg_file_cfg_parity.sv
// Combinational even-parity reduction: parity is the bit that makes the
// total number of ones in {data, parity} even.
module reg_file_cfg_parity #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  output logic             parity
);

  assign parity = ^data;

endmodule

// File: rtl/reg_file_cfg.sv
// reg_file_cfg: single-port register file with a shared read/write address,
// registered read data with a one-cycle valid pulse, and an address/conflict
// error pulse. Entries 0..3 are exported continuously as configuration regs.
//
// Optional feature macro: REG_FILE_CFG_PARITY_EN
//   When defined, each entry carries an even-parity bit computed on write and
//   a read of an entry whose stored parity disagrees pulses ParErr alongside
//   RdData_Valid. When undefined, neither the port nor the storage exist.
//
// Handshake: there is no backpressure. WrEn/RdEn are single-cycle requests
// sampled on the rising edge; exactly one of them with an in-range address is
// a legal access. Both together, or either with Address >= DEPTH, is rejected
// and reported one cycle later on AddrErr. RdData is qualified by RdData_Valid
// and otherwise holds its previous value.
module reg_file_cfg
  import reg_file_cfg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int ADDR  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             WrEn,
  input  logic             RdEn,
  input  logic [ADDR-1:0]  Address,
  input  logic [WIDTH-1:0] WrData,
  output logic [WIDTH-1:0] RdData,
  output logic             RdData_Valid,
  output logic             AddrErr,
  output logic [WIDTH-1:0] REG0,
  output logic [WIDTH-1:0] REG1,
  output logic [WIDTH-1:0] REG2,
  output logic [WIDTH-1:0] REG3
`ifdef REG_FILE_CFG_PARITY_EN
  ,
  output logic             ParErr
`endif
);

  // DEPTH widened by one bit so the compare is exact even when DEPTH is a
  // power of two and every Address value is in range.
  localparam logic [ADDR:0] DEPTH_W = (ADDR+1)'(DEPTH);

  logic             addr_ok;
  logic             conflict;
  logic             wr_ok;
  logic             rd_ok;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic [WIDTH-1:0] rd_data_q;
  logic [WIDTH-1:0] rd_data_d;
  logic             rd_valid_q;
  logic             rd_valid_d;
  logic             addr_err_q;
  logic             addr_err_d;

  assign addr_ok  = ({1'b0, Address} < DEPTH_W);
  assign conflict = WrEn & RdEn;
  assign wr_ok    = WrEn & ~RdEn & addr_ok;
  assign rd_ok    = RdEn & ~WrEn & addr_ok;

  // Next storage contents: only a legal, in-range write modifies an entry.
  always_comb begin
    mem_d = mem_q;
    if (wr_ok) begin
      mem_d[Address] = WrData;
    end
  end

  // Next read-side outputs: capture on a legal read, otherwise hold data.
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_ok;
    addr_err_d = conflict | ((WrEn | RdEn) & ~addr_ok);
    if (rd_ok) begin
      rd_data_d = mem_q[Address];
    end
  end

  // Storage flops; reset loads the configuration defaults.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= WIDTH'(rst_val(i));
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read-side output flops; reset drops any request of this cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign RdData       = rd_data_q;
  assign RdData_Valid = rd_valid_q;
  assign AddrErr      = addr_err_q;
  assign REG0         = mem_q[0];
  assign REG1         = mem_q[1];
  assign REG2         = mem_q[2];
  assign REG3         = mem_q[3];

`ifdef REG_FILE_CFG_PARITY_EN
  logic             par_q [DEPTH];
  logic             par_d [DEPTH];
  logic             wr_par;
  logic             rd_par;
  logic             par_err_q;
  logic             par_err_d;

  reg_file_cfg_parity #(.WIDTH(WIDTH)) u_wr_parity (
    .data   (WrData),
    .parity (wr_par)
  );

  reg_file_cfg_parity #(.WIDTH(WIDTH)) u_rd_parity (
    .data   (mem_q[Address]),
    .parity (rd_par)
  );

  // Next parity storage: parity of the write data alongside the entry.
  always_comb begin
    par_d     = par_q;
    par_err_d = rd_ok & (rd_par != par_q[Address]);
    if (wr_ok) begin
      par_d[Address] = wr_par;
    end
  end

  // Parity flops; reset stores the parity of each reset value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        par_q[i] <= ^(WIDTH'(rst_val(i)));
      end
      par_err_q <= 1'b0;
    end else begin
      par_q     <= par_d;
      par_err_q <= par_err_d;
    end
  end

  assign ParErr = par_err_q;
`endif

endmodule

// File: tb/tb_reg_file_cfg.sv
// Self-checking bench for reg_file_cfg (DEPTH=12 so out-of-range addresses
// are reachable). A behavioural model holds the register contents in a plain
// array and derives expected outputs from the access rules per cycle.
module tb_reg_file_cfg;

  localparam int WIDTH = 8;
  localparam int DEPTH = 12;
  localparam int ADDR  = 4;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             wr_en = 1'b0;
  logic             rd_en = 1'b0;
  logic [ADDR-1:0]  address = '0;
  logic [WIDTH-1:0] wr_data = '0;

  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             addr_err;
  logic [WIDTH-1:0] reg0, reg1, reg2, reg3;
`ifdef REG_FILE_CFG_PARITY_EN
  logic             par_err;
  logic             flip4 = 1'b0;
`endif

  always #5 clk = ~clk;

  reg_file_cfg #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR)) dut (
    .clk          (clk),
    .rst          (rst),
    .WrEn         (wr_en),
    .RdEn         (rd_en),
    .Address      (address),
    .WrData       (wr_data),
    .RdData       (rd_data),
    .RdData_Valid (rd_valid),
    .AddrErr      (addr_err),
    .REG0         (reg0),
    .REG1         (reg1),
    .REG2         (reg2),
    .REG3         (reg3)
`ifdef REG_FILE_CFG_PARITY_EN
    ,
    .ParErr       (par_err)
`endif
  );

  // ---------------- model / scoreboard ----------------
  logic [WIDTH-1:0] m_mem [DEPTH];
  logic [WIDTH-1:0] m_rd;
  logic [WIDTH-1:0] exp_q [$];
  int               n_checks = 0;
  int               n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_mem[2] = 8'h81;
    m_mem[3] = 8'd32;
    m_rd = '0;
    exp_q.delete();
  endfunction

  // ---------------- driver ----------------
  // One clock cycle: drive request at negedge, let the edge happen, then
  // update the model and compare all outputs at the following negedge.
  task automatic step(input logic r, input logic w, input logic rd, input int a,
                      input logic [WIDTH-1:0] d);
    logic exp_valid;
    logic exp_err;
    logic exp_par;
    rst     = r;
    wr_en   = w;
    rd_en   = rd;
    address = ADDR'(a);
    wr_data = d;
    @(posedge clk);
    @(negedge clk);
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    exp_par   = 1'b0;
    if (!r) begin
      model_reset();
    end else if (w && rd) begin
      exp_err = 1'b1;
    end else if ((w || rd) && a >= DEPTH) begin
      exp_err = 1'b1;
    end else if (w) begin
      m_mem[a] = d;
    end else if (rd) begin
      exp_valid = 1'b1;
      exp_q.push_back(m_mem[a]);
`ifdef REG_FILE_CFG_PARITY_EN
      exp_par = flip4 && (a == 4);
`endif
    end
    if (exp_valid) m_rd = exp_q.pop_front();
    check("rd_valid", 32'(rd_valid), 32'(exp_valid));
    check("addr_err", 32'(addr_err), 32'(exp_err));
    check("rd_data",  32'(rd_data),  32'(m_rd));
    check("reg0",     32'(reg0),     32'(m_mem[0]));
    check("reg1",     32'(reg1),     32'(m_mem[1]));
    check("reg2",     32'(reg2),     32'(m_mem[2]));
    check("reg3",     32'(reg3),     32'(m_mem[3]));
`ifdef REG_FILE_CFG_PARITY_EN
    check("par_err",  32'(par_err),  32'(exp_par));
`else
    if (exp_par) check("par_err_model", 32'(exp_par), 32'(0));
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    @(negedge clk);
    step(1'b0, 1'b0, 1'b0, 0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 0, 8'hEE);  // request during reset is discarded
    check("reset_reg0", 32'(reg0), 32'h00);
    check("reset_reg2", 32'(reg2), 32'h81);
    check("reset_reg3", 32'(reg3), 32'h20);

    // Reset values read back through the read port.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, i, 8'h00);
    check("rd3_const", 32'(rd_data), 32'h20);

    // Writes then back-to-back reads.
    step(1'b1, 1'b1, 1'b0, 7, 8'h01);
    step(1'b1, 1'b1, 1'b0, 1, 8'h1C);
    step(1'b1, 1'b1, 1'b0, 5, 8'h0A);
    step(1'b1, 1'b0, 1'b1, 7, 8'h00);
    check("b2b_7", 32'(rd_data), 32'h01);
    step(1'b1, 1'b0, 1'b1, 1, 8'h00);
    check("b2b_1", 32'(rd_data), 32'h1C);
    step(1'b1, 1'b0, 1'b1, 5, 8'h00);
    check("b2b_5", 32'(rd_data), 32'h0A);

    // Write reg0, then reset mid-stream.
    step(1'b1, 1'b1, 1'b0, 0, 8'h5A);
    check("reg0_5a", 32'(reg0), 32'h5A);
    step(1'b0, 1'b0, 1'b1, 0, 8'h00);
    check("reg0_rst", 32'(reg0), 32'h00);

    // Conflicting request on entry 2.
    step(1'b1, 1'b1, 1'b1, 2, 8'hFF);
    check("conflict_reg2", 32'(reg2), 32'h81);
    step(1'b1, 1'b0, 1'b1, 2, 8'h00);

    // Out-of-range accesses leave RdData holding 0x81.
    step(1'b1, 1'b1, 1'b0, 13, 8'h33);
    step(1'b1, 1'b0, 1'b1, 13, 8'h00);
    check("oor_hold", 32'(rd_data), 32'h81);
    step(1'b1, 1'b0, 1'b1, 12, 8'h00);
    step(1'b1, 1'b0, 1'b1, 11, 8'h00);

    // Read immediately after write.
    step(1'b1, 1'b1, 1'b0, 9, 8'hC3);
    step(1'b1, 1'b0, 1'b1, 9, 8'h00);
    check("raw_9", 32'(rd_data), 32'hC3);

`ifdef REG_FILE_CFG_PARITY_EN
    step(1'b1, 1'b1, 1'b0, 4, 8'h0F);
    force dut.par_q[4] = 1'b1;
    flip4 = 1'b1;
    step(1'b1, 1'b0, 1'b1, 4, 8'h00);
    release dut.par_q[4];
    step(1'b1, 1'b1, 1'b0, 4, 8'h0F);
    flip4 = 1'b0;
`endif

    // Randomized traffic including occasional resets.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 49) != 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 1) == 0),
           $urandom_range(0, 15),
           WIDTH'($urandom));
    end

    check("exp_q_empty", 32'(exp_q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
